// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing one data-memory bus between NUM_MASTERS load/store units.
// Latency: request in IDLE at t, slave strobes and zero-wait completion at t+1; at most one transaction per 2 cycles.
// Backpressure: masters hold their request until m_ready; the slave stalls via s_ready, bounded by a watchdog.
module data_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [32*NUM_MASTERS-1:0] m_address,
    input  logic [32*NUM_MASTERS-1:0] m_write_data,
    input  logic [4*NUM_MASTERS-1:0]  m_byte_enable,
    input  logic [NUM_MASTERS-1:0]    m_write_enable,
    input  logic [NUM_MASTERS-1:0]    m_read_enable,
    output logic [31:0]               m_read_data,
    output logic [NUM_MASTERS-1:0]    m_ready,
    output logic [NUM_MASTERS-1:0]    m_error,
    output logic [31:0]               s_address,
    output logic [31:0]               s_write_data,
    output logic [3:0]                s_byte_enable,
    output logic                      s_write_enable,
    output logic                      s_read_enable,
    input  logic [31:0]               s_read_data,
    input  logic                      s_ready,
    output logic                      busy,
    output logic [2:0]                grant_id
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state;
    logic [GW-1:0]          grant_q;
    logic [GW-1:0]          rr_ptr;
    logic [GW-1:0]          winner;
    logic [GW-1:0]          grant_next;
    logic [15:0]            wd_cnt;
    logic [NUM_MASTERS-1:0] req;
    logic                   any_req;
    logic                   timeout;
    logic                   done;

    logic [31:0] addr_a [NUM_MASTERS];
    logic [31:0] wdat_a [NUM_MASTERS];
    logic [3:0]  be_a   [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign addr_a[i] = m_address[32*i +: 32];
        assign wdat_a[i] = m_write_data[32*i +: 32];
        assign be_a[i]   = m_byte_enable[4*i +: 4];
    end

    assign req     = m_read_enable | m_write_enable;
    assign any_req = |req;

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        logic [GW-1:0] idx;
        winner = rr_ptr;
        idx    = rr_ptr;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            idx = GW'((int'(rr_ptr) + k) % NUM_MASTERS);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign grant_next = (grant_q == GW'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
    assign timeout    = (TIMEOUT_CYCLES != 0) && (state == BUSY) && !s_ready &&
                        (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign done       = (state == BUSY) && (s_ready || timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            wd_cnt  <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= winner;
                        wd_cnt  <= '0;
                        state   <= BUSY;
                        busy    <= 1'b1;
                    end
                end
                BUSY: begin
                    if (done) begin
                        rr_ptr <= grant_next;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_id = 3'(grant_q);

    // Bus is quiet outside BUSY, so a reset in flight silences the slave port at once.
    always_comb begin
        s_address      = '0;
        s_write_data   = '0;
        s_byte_enable  = '0;
        s_write_enable = 1'b0;
        s_read_enable  = 1'b0;
        m_ready        = '0;
        m_error        = '0;
        m_read_data    = '0;
        if (state == BUSY) begin
            s_address      = addr_a[grant_q];
            s_write_data   = wdat_a[grant_q];
            s_byte_enable  = be_a[grant_q];
            s_write_enable = m_write_enable[grant_q];
            s_read_enable  = m_read_enable[grant_q];
            if (done) begin
                m_ready[grant_q] = 1'b1;
                m_error[grant_q] = timeout;
                m_read_data      = timeout ? 32'd0 : s_read_data;
            end
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: a 4-master instance with an 8-cycle watchdog checked against a
// transaction-level reference model, plus a 3-master instance with the watchdog disabled.
module tb_data_bus_arbiter;

    localparam int NA = 4;
    localparam int TA = 8;
    localparam int NB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: 4 masters, watchdog 8
    logic           rst_a;
    logic [32*NA-1:0] a_addr, a_wdat;
    logic [4*NA-1:0]  a_be;
    logic [NA-1:0]    a_we, a_re, a_ready, a_error;
    logic [31:0]      a_rdata, a_saddr, a_swdat, a_srdata;
    logic [3:0]       a_sbe;
    logic             a_swe, a_sre, a_sready, a_busy;
    logic [2:0]       a_gid;

    data_bus_arbiter #(.NUM_MASTERS(NA), .TIMEOUT_CYCLES(TA)) u_dut_a (
        .clk(clk), .rst(rst_a),
        .m_address(a_addr), .m_write_data(a_wdat), .m_byte_enable(a_be),
        .m_write_enable(a_we), .m_read_enable(a_re),
        .m_read_data(a_rdata), .m_ready(a_ready), .m_error(a_error),
        .s_address(a_saddr), .s_write_data(a_swdat), .s_byte_enable(a_sbe),
        .s_write_enable(a_swe), .s_read_enable(a_sre),
        .s_read_data(a_srdata), .s_ready(a_sready),
        .busy(a_busy), .grant_id(a_gid)
    );

    // Instance B: 3 masters, watchdog off
    logic             rst_b;
    logic [32*NB-1:0] b_addr, b_wdat;
    logic [4*NB-1:0]  b_be;
    logic [NB-1:0]    b_we, b_re, b_ready, b_error;
    logic [31:0]      b_rdata, b_saddr, b_swdat, b_srdata;
    logic [3:0]       b_sbe;
    logic             b_swe, b_sre, b_sready, b_busy;
    logic [2:0]       b_gid;

    data_bus_arbiter #(.NUM_MASTERS(NB), .TIMEOUT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .m_address(b_addr), .m_write_data(b_wdat), .m_byte_enable(b_be),
        .m_write_enable(b_we), .m_read_enable(b_re),
        .m_read_data(b_rdata), .m_ready(b_ready), .m_error(b_error),
        .s_address(b_saddr), .s_write_data(b_swdat), .s_byte_enable(b_sbe),
        .s_write_enable(b_swe), .s_read_enable(b_sre),
        .s_read_data(b_srdata), .s_ready(b_sready),
        .busy(b_busy), .grant_id(b_gid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model of A: who owns the bus, how long it has waited, who has priority next.
    bit md_busy;
    int md_owner, md_ptr, md_elapsed;
    bit last_fin;
    int last_owner;
    logic [31:0] obs_rdata, obs_saddr, obs_swdat;
    logic [3:0]  obs_ready, obs_error, obs_sbe;
    logic [2:0]  obs_gid;
    logic        obs_busy, obs_sre, obs_swe;

    task automatic model_reset();
        md_busy = 0; md_owner = 0; md_ptr = 0; md_elapsed = 0; last_fin = 0;
    endtask

    task automatic do_reset_a();
        rst_a = 1'b1;
        #2;
        rst_a = 1'b0;
        model_reset();
    endtask

    // Called just after a rising edge with inputs set; checks mid-cycle then advances one cycle.
    task automatic step_a();
        logic [31:0] e_saddr, e_swdat, e_rdata;
        logic [3:0]  e_sbe, e_ready, e_error;
        logic        e_swe, e_sre;
        int o;
        bit fin, tmo;
        #4;
        e_saddr = '0; e_swdat = '0; e_rdata = '0; e_sbe = '0;
        e_ready = '0; e_error = '0; e_swe = 1'b0; e_sre = 1'b0;
        fin = 0; tmo = 0; o = md_owner;
        if (md_busy) begin
            e_saddr = a_addr[32*o +: 32];
            e_swdat = a_wdat[32*o +: 32];
            e_sbe   = a_be[4*o +: 4];
            e_swe   = a_we[o];
            e_sre   = a_re[o];
            if (a_sready) fin = 1;
            else if (TA != 0 && md_elapsed + 1 == TA) begin fin = 1; tmo = 1; end
            if (fin) begin
                e_ready[o] = 1'b1;
                e_error[o] = tmo;
                e_rdata    = tmo ? 32'd0 : a_srdata;
            end
        end
        obs_rdata = a_rdata; obs_saddr = a_saddr; obs_swdat = a_swdat; obs_ready = a_ready;
        obs_error = a_error; obs_sbe = a_sbe; obs_gid = a_gid; obs_busy = a_busy;
        obs_sre = a_sre; obs_swe = a_swe;
        chk("a_busy",  32'(a_busy),  32'(md_busy));
        chk("a_grant", 32'(a_gid),   32'(md_owner));
        chk("a_saddr", a_saddr,      e_saddr);
        chk("a_swdat", a_swdat,      e_swdat);
        chk("a_sbe",   32'(a_sbe),   32'(e_sbe));
        chk("a_swe",   32'(a_swe),   32'(e_swe));
        chk("a_sre",   32'(a_sre),   32'(e_sre));
        chk("a_ready", 32'(a_ready), 32'(e_ready));
        chk("a_error", 32'(a_error), 32'(e_error));
        chk("a_rdata", a_rdata,      e_rdata);
        if (!md_busy) begin
            if ((a_re | a_we) != '0) begin
                for (int k = 0; k < NA; k++) begin
                    int j;
                    j = (md_ptr + k) % NA;
                    if (a_re[j] | a_we[j]) begin
                        md_owner = j;
                        break;
                    end
                end
                md_busy = 1; md_elapsed = 0;
            end
        end else if (fin) begin
            md_busy = 0;
            md_ptr  = (md_owner + 1) % NA;
        end else begin
            md_elapsed++;
        end
        last_fin = fin; last_owner = o;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bo_rdata;
    logic [2:0]  bo_gid, bo_ready, bo_error;
    logic        bo_busy;

    task automatic step_b();
        #4;
        bo_rdata = b_rdata; bo_gid = b_gid; bo_ready = b_ready; bo_error = b_error; bo_busy = b_busy;
        @(posedge clk);
        #1;
    endtask

    bit pend [NA];
    int bad_busy, bad_rdy;
    logic [31:0] exp_one;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        a_addr = '0; a_wdat = '0; a_be = '0; a_we = '0; a_re = '0; a_srdata = '0; a_sready = 1'b0;
        b_addr = '0; b_wdat = '0; b_be = '0; b_we = '0; b_re = '0; b_srdata = '0; b_sready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a_re = 4'b1111; a_sready = 1'b1;
        #1;
        chk("rst_busy",  32'(a_busy),  32'd0);
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_gid",   32'(a_gid),   32'd0);
        chk("rst_sre",   32'(a_sre),   32'd0);
        chk("rst_saddr", a_saddr,      32'd0);
        a_re = '0; a_sready = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        model_reset();

        // Single load from master 0, slave answers one cycle after the strobe
        a_re[0] = 1'b1; a_addr[31:0] = 32'h100;
        step_a();
        chk("ld_idle_sre", 32'(obs_sre), 32'd0);
        step_a();
        chk("ld_strobe1", 32'(obs_sre), 32'd1);
        chk("ld_noready", 32'(obs_ready), 32'd0);
        a_sready = 1'b1; a_srdata = 32'hDEADBEEF;
        step_a();
        chk("ld_strobe2", 32'(obs_sre), 32'd1);
        chk("ld_ready",   32'(obs_ready), 32'b0001);
        chk("ld_rdata",   obs_rdata, 32'hDEADBEEF);
        chk("ld_saddr",   obs_saddr, 32'h100);
        a_re = '0;
        step_a();
        chk("ld_done_rdata", obs_rdata, 32'd0);

        // Two simultaneous stores, zero-wait slave
        do_reset_a();
        a_we = 4'b0011; a_sready = 1'b1;
        a_wdat[31:0] = 32'h1111_AAAA; a_be[3:0] = 4'b0011;
        a_wdat[63:32] = 32'h2222_BBBB; a_be[7:4] = 4'b1100;
        step_a();
        chk("st_idle_busy", 32'(obs_busy), 32'd0);
        step_a();
        chk("st_m0_gid",   32'(obs_gid), 32'd0);
        chk("st_m0_ready", 32'(obs_ready), 32'b0001);
        chk("st_m0_be",    32'(obs_sbe), 32'b0011);
        chk("st_m0_wdat",  obs_swdat, 32'h1111_AAAA);
        a_we[0] = 1'b0;
        step_a();
        step_a();
        chk("st_m1_gid",   32'(obs_gid), 32'd1);
        chk("st_m1_ready", 32'(obs_ready), 32'b0010);
        chk("st_m1_be",    32'(obs_sbe), 32'b1100);
        chk("st_m1_wdat",  obs_swdat, 32'h2222_BBBB);
        a_we = '0;
        step_a();

        // Fairness: all four request continuously for 12 transactions
        do_reset_a();
        a_re = 4'b1111; a_sready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            step_a();
            step_a();
            exp_one = 32'd1 << (t % NA);
            chk($sformatf("fair_gid_%0d", t), 32'(obs_gid), 32'(t % NA));
            chk($sformatf("fair_rdy_%0d", t), 32'(obs_ready), exp_one);
        end
        a_re = '0;
        step_a();

        // Watchdog: slave never answers master 2's store
        a_sready = 1'b0; a_srdata = 32'hCAFE_F00D;
        a_we[2] = 1'b1; a_addr[95:64] = 32'h0000_2000;
        step_a();
        for (int c = 1; c <= TA; c++) begin
            step_a();
            if (c < TA) chk($sformatf("wd_wait_%0d", c), 32'(obs_ready), 32'd0);
        end
        chk("wd_ready", 32'(obs_ready), 32'b0100);
        chk("wd_error", 32'(obs_error), 32'b0100);
        chk("wd_rdata", obs_rdata, 32'd0);
        a_we = '0;
        step_a();
        chk("wd_idle", 32'(obs_busy), 32'd0);

        // Reset in the middle of a BUSY transaction
        do_reset_a();
        a_sready = 1'b1;
        a_re = 4'b0010; a_addr[63:32] = 32'h1111_0000; a_addr[127:96] = 32'h3333_0000;
        step_a();
        step_a();
        chk("rm_m1_gid", 32'(obs_gid), 32'd1);
        a_re = 4'b1010; a_sready = 1'b0;
        step_a();
        step_a();
        chk("rm_m3_gid",   32'(obs_gid), 32'd3);
        chk("rm_m3_saddr", obs_saddr, 32'h3333_0000);
        #2;
        rst_a = 1'b1;
        #1;
        chk("rm_saddr", a_saddr, 32'd0);
        chk("rm_sre",   32'(a_sre), 32'd0);
        chk("rm_busy",  32'(a_busy), 32'd0);
        chk("rm_ready", 32'(a_ready), 32'd0);
        chk("rm_gid",   32'(a_gid), 32'd0);
        #1;
        rst_a = 1'b0;
        model_reset();
        step_a();
        step_a();
        chk("rm_after_gid",   32'(obs_gid), 32'd1);
        chk("rm_after_saddr", obs_saddr, 32'h1111_0000);
        a_sready = 1'b1;
        step_a();
        chk("rm_after_ready", 32'(obs_ready), 32'b0010);
        a_re = '0;
        step_a();

        // Randomised traffic against the model
        for (int i = 0; i < NA; i++) pend[i] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NA; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    logic [1:0] op;
                    op = 2'($urandom_range(1, 3));
                    pend[i] = 1;
                    a_addr[32*i +: 32] = $urandom();
                    a_wdat[32*i +: 32] = $urandom();
                    a_be[4*i +: 4]     = 4'($urandom());
                    a_re[i] = op[0];
                    a_we[i] = op[1];
                end else if (!pend[i]) begin
                    a_re[i] = 1'b0;
                    a_we[i] = 1'b0;
                end
            end
            a_sready = ($urandom % 6 == 0);
            a_srdata = $urandom();
            step_a();
            if (last_fin) pend[last_owner] = 0;
        end
        a_re = '0; a_we = '0;

        // Instance B: three-way rotation including the non-power-of-two wrap
        b_re = 3'b111; b_sready = 1'b1;
        for (int t = 0; t < 9; t++) begin
            step_b();
            chk($sformatf("b_idle_%0d", t), 32'(bo_busy), 32'd0);
            step_b();
            exp_one = 32'd1 << (t % NB);
            chk($sformatf("b_gid_%0d", t), 32'(bo_gid), 32'(t % NB));
            chk($sformatf("b_rdy_%0d", t), 32'(bo_ready), exp_one);
        end
        b_re = '0;
        step_b();

        // Instance B: watchdog disabled, slave silent for 1000 cycles
        b_re[2] = 1'b1; b_sready = 1'b0;
        step_b();
        bad_busy = 0; bad_rdy = 0;
        for (int c = 0; c < 1000; c++) begin
            step_b();
            if (bo_busy !== 1'b1) bad_busy++;
            if (bo_ready !== 3'b000 || bo_error !== 3'b000) bad_rdy++;
        end
        chk("b_wdoff_busy",  32'(bad_busy), 32'd0);
        chk("b_wdoff_ready", 32'(bad_rdy),  32'd0);
        b_sready = 1'b1; b_srdata = 32'h0BAD_F00D;
        step_b();
        chk("b_late_ready", 32'(bo_ready), 32'b100);
        chk("b_late_error", 32'(bo_error), 32'b000);
        chk("b_late_rdata", bo_rdata, 32'h0BAD_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
